encoder_round_sequencer: RTL and testbench

//  Parametrised round/stage sequencer for the encoder datapath. Runs NUM_ROUNDS rounds.

---
 rtl/encoder_round_sequencer_pkg.sv | 19 +
 rtl/encoder_round_sequencer_next_sel.sv | 35 +++
 rtl/encoder_round_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_encoder_round_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_round_sequencer_pkg.sv
// Shared definitions for the encoder round sequencer.
//   seq_state_e : sequencer FSM state encoding
//   clog2_min1  : ceil(log2(value)), never less than 1, so that index and
//                 timer widths stay legal for degenerate parameter values
package encoder_round_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } seq_state_e;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/encoder_round_sequencer_next_sel.sv
// Combinational priority search over the stage bypass mask.
// Ports:
//   mask          in  enabled stages (1 = run)
//   cur_idx       in  stage currently being sequenced
//   next_idx      out lowest enabled stage above cur_idx (0 when none)
//   first_idx     out lowest enabled stage in the mask (0 when mask is empty)
//   last_in_round out no enabled stage above cur_idx
module encoder_round_sequencer_next_sel #(
    parameter int NUM_STAGES = 5,
    parameter int IDX_W      = 3
) (
    input  logic [NUM_STAGES-1:0] mask,
    input  logic [IDX_W-1:0]      cur_idx,
    output logic [IDX_W-1:0]      next_idx,
    output logic [IDX_W-1:0]      first_idx,
    output logic                  last_in_round
);

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        first_idx     = '0;
        next_idx      = '0;
        last_in_round = 1'b1;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = IDX_W'(i);
                if (i > int'(cur_idx)) begin
                    next_idx      = IDX_W'(i);
                    last_in_round = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/encoder_round_sequencer.sv
// Round/stage sequencer for the encoder datapath. Runs NUM_ROUNDS rounds; in
// each round the enabled step units are started in ascending order through a
// start/finish handshake. Includes a bypass mask, per-stage watchdog, abort
// and a saturating run cycle counter.
// Ports:
//   clk           in  clock, rising edge
//   rst           in  asynchronous reset, active-low despite its name
//   start         in  run request, sampled only in IDLE
//   abort         in  cancel the current run
//   stage_en      in  bypass mask (1 = run stage), latched when start is accepted
//   stage_finish  in  per-stage done from the step units
//   stage_start   out one-hot, one-cycle start pulse to the selected step unit
//   iteration     out current round
//   busy          out run in progress
//   finish        out one-cycle pulse on normal completion
//   error         out sticky watchdog error, cleared by the next accepted start
//   error_stage   out stage that timed out, valid while error=1
//   cycle_count   out cycles of the last/current run, saturating
//
// state  | meaning
// IDLE   | waiting for start; outputs hold results of the last run
// LAUNCH | stage_start pulse to stage_idx; a finish here counts as completion
// WAIT   | waiting for stage_finish[stage_idx]; watchdog running
// DONE   | finish pulse, then IDLE
// ERR    | watchdog expired, one cycle, then IDLE with error held
module encoder_round_sequencer
    import encoder_round_sequencer_pkg::*;
#(
    parameter int  NUM_STAGES = 5,
    parameter int  NUM_ROUNDS = 24,
    parameter int  ROUND_W    = 6,
    parameter int  TIMEOUT    = 1023,
    parameter int  CNT_W      = 16,
    localparam int IDX_W      = clog2_min1(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_en,
    input  logic [NUM_STAGES-1:0] stage_finish,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [ROUND_W-1:0]    iteration,
    output logic                  busy,
    output logic                  finish,
    output logic                  error,
    output logic [IDX_W-1:0]      error_stage,
    output logic [CNT_W-1:0]      cycle_count
);

    localparam int                 TMR_W      = clog2_min1(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'(TIMEOUT);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    seq_state_e            state_q, state_d;
    logic [NUM_STAGES-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]      stage_idx_q, stage_idx_d;
    logic [ROUND_W-1:0]    iteration_q, iteration_d;
    logic [TMR_W-1:0]      wdog_q, wdog_d;
    logic                  error_q, error_d;
    logic [IDX_W-1:0]      error_stage_q, error_stage_d;
    logic [CNT_W-1:0]      cycle_count_q, cycle_count_d;

    logic [NUM_STAGES-1:0] sel_mask;
    logic [IDX_W-1:0]      next_idx, first_idx;
    logic                  last_in_round;
    logic                  stage_done;

    // In IDLE the live input mask picks the first stage for the run being accepted.
    assign sel_mask   = (state_q == S_IDLE) ? stage_en : mask_q;
    assign stage_done = stage_finish[stage_idx_q];

    encoder_round_sequencer_next_sel #(
        .NUM_STAGES (NUM_STAGES),
        .IDX_W      (IDX_W)
    ) u_next_sel (
        .mask          (sel_mask),
        .cur_idx       (stage_idx_q),
        .next_idx      (next_idx),
        .first_idx     (first_idx),
        .last_in_round (last_in_round)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            stage_idx_q   <= '0;
            iteration_q   <= '0;
            wdog_q        <= '0;
            error_q       <= 1'b0;
            error_stage_q <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            stage_idx_q   <= stage_idx_d;
            iteration_q   <= iteration_d;
            wdog_q        <= wdog_d;
            error_q       <= error_d;
            error_stage_q <= error_stage_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        stage_idx_d   = stage_idx_q;
        iteration_d   = iteration_q;
        wdog_d        = wdog_q;
        error_d       = error_q;
        error_stage_d = error_stage_q;
        cycle_count_d = cycle_count_q;

        if (state_q != S_IDLE && cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d        = stage_en;
                    error_d       = 1'b0;
                    error_stage_d = '0;
                    cycle_count_d = '0;
                    iteration_d   = '0;
                    if (|stage_en) begin
                        stage_idx_d = first_idx;
                        state_d     = S_LAUNCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LAUNCH, S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (stage_done) begin
                    if (!last_in_round) begin
                        stage_idx_d = next_idx;
                        state_d     = S_LAUNCH;
                    end else if (iteration_q != LAST_ROUND) begin
                        iteration_d = iteration_q + 1'b1;
                        stage_idx_d = first_idx;
                        state_d     = S_LAUNCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (state_q == S_LAUNCH) begin
                    state_d = S_WAIT;
                end else if (TIMEOUT != 0 && wdog_q == TMR_W'(1)) begin
                    state_d       = S_ERR;
                    error_d       = 1'b1;
                    error_stage_d = stage_idx_q;
                end else begin
                    wdog_d = wdog_q - 1'b1;
                end
                // Down-counter reloads on every launch; expiry is the 1 -> 0 step in WAIT.
                if (state_q == S_LAUNCH) begin
                    wdog_d = TMR_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stage_start = '0;
        if (state_q == S_LAUNCH) begin
            stage_start[stage_idx_q] = 1'b1;
        end
        busy        = (state_q != S_IDLE);
        finish      = (state_q == S_DONE);
        iteration   = iteration_q;
        error       = error_q;
        error_stage = error_stage_q;
        cycle_count = cycle_count_q;
    end

endmodule

// File: tb/tb_encoder_round_sequencer.sv
// Directed bench for encoder_round_sequencer. Two instances share all inputs:
// u_dut_a uses default parameters, u_dut_b uses TIMEOUT=8 for the watchdog case.
module tb_encoder_round_sequencer;

    localparam int NR = 24;

    logic       clk, rst, start, abort;
    logic [4:0] stage_en, stage_finish;
    logic [4:0] ss_a, ss_b;
    logic [5:0] it_a, it_b;
    logic       busy_a, busy_b, fin_a, fin_b, err_a, err_b;
    logic [2:0] es_a, es_b;
    logic [15:0] cc_a, cc_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // responder controls: 0 = silent, 1 = finish one cycle after start, 2 = same cycle
    int resp_mode = 0;
    bit kill_en   = 0;
    bit stray_en  = 0;
    logic [4:0] last_ss;

    int exp_order[$];
    int mon_ptr, mon_pulses, mon_s;
    bit mon_en = 0;

    encoder_round_sequencer u_dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .stage_en(stage_en), .stage_finish(stage_finish),
        .stage_start(ss_a), .iteration(it_a), .busy(busy_a), .finish(fin_a),
        .error(err_a), .error_stage(es_a), .cycle_count(cc_a)
    );

    encoder_round_sequencer #(.TIMEOUT(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .stage_en(stage_en), .stage_finish(stage_finish),
        .stage_start(ss_b), .iteration(it_b), .busy(busy_b), .finish(fin_b),
        .error(err_b), .error_stage(es_b), .cycle_count(cc_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timed out");
    end

    // Step-unit model driven mid-cycle so it is stable at the sampling edge.
    initial begin
        logic [4:0] fin;
        last_ss      = '0;
        stage_finish = '0;
        forever begin
            @(negedge clk);
            fin = '0;
            if (resp_mode == 1) fin = last_ss;
            else if (resp_mode == 2) fin = ss_a;
            if (kill_en && it_a == 6'd2) fin[3] = 1'b0;
            if (stray_en) fin = fin | (5'($urandom) & ~(ss_a | last_ss));
            stage_finish = fin;
            last_ss = ss_a;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mon_en && ss_a != '0) begin
            if (mon_ptr < exp_order.size()) begin
                check("pulse_order", 32'(ss_a), 32'(1 << exp_order[mon_ptr]));
                check("pulse_iter", 32'(it_a), 32'(mon_ptr / mon_s));
            end else begin
                check("extra_pulse", 32'(mon_ptr), 32'(exp_order.size()));
            end
            mon_ptr++;
            mon_pulses++;
        end
    end

    task automatic arm_monitor(input logic [4:0] mask);
        exp_order.delete();
        for (int r = 0; r < NR; r++)
            for (int s = 0; s < 5; s++)
                if (mask[s]) exp_order.push_back(s);
        mon_s      = ($countones(mask) == 0) ? 1 : $countones(mask);
        mon_ptr    = 0;
        mon_pulses = 0;
    endtask

    task automatic run_case(input string name, input logic [4:0] mask, input int mode,
                            input bit hold, input int exp_lat);
        int c0;
        bit seen;
        int s;
        s = $countones(mask);
        @(negedge clk);
        arm_monitor(mask);
        mon_en    = 1;
        resp_mode = mode;
        stage_en  = mask;
        start     = 1'b1;
        c0        = cyc;
        @(negedge clk);
        if (!hold) start = 1'b0;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            if (fin_a) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_finish_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(cyc - c0), 32'(exp_lat));
        check({name, "_finish_b"}, 32'(fin_b), 32'd1);
        start = 1'b0;
        @(negedge clk);
        check({name, "_busy_after"}, 32'(busy_a), 32'd0);
        check({name, "_finish_after"}, 32'(fin_a), 32'd0);
        check({name, "_cycle_count"}, 32'(cc_a), 32'(exp_lat));
        check({name, "_cycle_count_b"}, 32'(cc_b), 32'(exp_lat));
        check({name, "_iteration"}, 32'(it_a), (s != 0) ? 32'(NR - 1) : 32'd0);
        check({name, "_pulses"}, 32'(mon_pulses), 32'(s * NR));
        check({name, "_error"}, 32'(err_a), 32'd0);
        mon_en = 0;
    endtask

    initial begin
        int  lc, c0;
        bit  seen;
        rst      = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        stage_en = '0;
        repeat (3) @(negedge clk);
        check("rst_stage_start", 32'(ss_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_finish", 32'(fin_a), 32'd0);
        check("rst_error", 32'(err_a), 32'd0);
        check("rst_iteration", 32'(it_a), 32'd0);
        check("rst_cycle_count", 32'(cc_a), 32'd0);
        check("rst_error_stage", 32'(es_a), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // full mask, one-cycle units: 2*5*24+1
        run_case("t1", 5'h1F, 1, 1'b0, 241);
        // zero-latency units: 5*24+1
        run_case("t1z", 5'h1F, 2, 1'b0, 121);
        // sparse mask: 2*3*24+1
        run_case("t2", 5'b10101, 1, 1'b0, 145);
        // empty mask: straight to DONE
        run_case("t3", 5'h00, 1, 1'b0, 1);

        // watchdog: stage 3 silent in round 2
        @(negedge clk);
        resp_mode = 1;
        kill_en   = 1;
        stage_en  = 5'h1F;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lc = 0;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (ss_b[3] && it_b == 6'd2) lc = cyc;
            if (err_b) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("t4_error_seen", 32'(seen), 32'd1);
        check("t4_wait_cycles", 32'(cyc - lc), 32'd9);
        check("t4_error_stage", 32'(es_b), 32'd3);
        check("t4_iteration", 32'(it_b), 32'd2);
        check("t4_busy_in_err", 32'(busy_b), 32'd1);
        check("t4_no_finish", 32'(fin_b), 32'd0);
        check("t4_a_no_error", 32'(err_a), 32'd0);
        @(negedge clk);
        check("t4_idle_after_err", 32'(busy_b), 32'd0);
        check("t4_error_sticky", 32'(err_b), 32'd1);
        check("t4_no_finish_idle", 32'(fin_b), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        kill_en = 0;
        check("t4_a_aborted", 32'(busy_a), 32'd0);
        check("t4_abort_idle_keeps_error", 32'(err_b), 32'd1);
        check("t4_abort_idle_keeps_stage", 32'(es_b), 32'd3);
        stage_en = 5'h1F;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_restart_clears_error", 32'(err_b), 32'd0);
        check("t4_restart_clears_stage", 32'(es_b), 32'd0);
        check("t4_restart_iteration", 32'(it_b), 32'd0);
        check("t4_restart_busy", 32'(busy_b), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_abort_a", 32'(busy_a), 32'd0);
        check("t4_abort_b", 32'(busy_b), 32'd0);

        // abort together with the very last stage finish
        @(negedge clk);
        resp_mode = 1;
        stage_en  = 5'h1F;
        start     = 1'b1;
        c0        = cyc;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (ss_a[4] && it_a == 6'd23) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("t5_last_launch_seen", 32'(seen), 32'd1);
        check("t5_last_launch_cycle", 32'(cyc - c0), 32'd239);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("t5_last_finish_driven", 32'(stage_finish[4]), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy_dropped", 32'(busy_a), 32'd0);
        check("t5_no_finish", 32'(fin_a), 32'd0);
        check("t5_no_error", 32'(err_a), 32'd0);
        check("t5_cycle_count", 32'(cc_a), 32'd240);
        check("t5_b_busy_dropped", 32'(busy_b), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_late_finish", 32'(fin_a), 32'd0);
        end

        // start held high and stray finishes on unselected bits
        stray_en = 1;
        run_case("t6", 5'h1F, 1, 1'b1, 241);

        // async reset in the middle of a WAIT
        @(negedge clk);
        stage_en = 5'h1F;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (it_a == 6'd1 && busy_a && ss_a == '0) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("t6_wait_reached", 32'(seen), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_stage_start", 32'(ss_a), 32'd0);
        check("t6_rst_busy", 32'(busy_a), 32'd0);
        check("t6_rst_iteration", 32'(it_a), 32'd0);
        check("t6_rst_cycle_count", 32'(cc_a), 32'd0);
        check("t6_rst_finish", 32'(fin_a), 32'd0);
        check("t6_rst_busy_b", 32'(busy_b), 32'd0);
        check("t6_rst_cycle_count_b", 32'(cc_b), 32'd0);
        stray_en = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_idle_after_rst", 32'(busy_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
